// File: rtl/trace_pkg.sv
// Shared widths and the packed entry layout for the commit trace buffer.
package trace_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SEQ_W      = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic [XLEN-1:0]       pc;
    logic [SEQ_W-1:0]      seq;
  } trace_entry_t;

  localparam int unsigned ENTRY_W = $bits(trace_entry_t);
endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted only
// together with a pop in the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retired register writes from the WB stage into a FIFO with sequence
// tags; never stalls the CPU, so writes that do not fit are dropped and counted.
module commit_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = trace_pkg::XLEN,
  parameter int unsigned SEQ_W = trace_pkg::SEQ_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wb_we,
  input  logic [trace_pkg::REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]                  wb_data,
  input  logic [XLEN-1:0]                  wb_pc,
  output logic                             trc_valid,
  input  logic                             trc_ready,
  output logic [trace_pkg::REG_ADDR_W-1:0] trc_rd,
  output logic [XLEN-1:0]                  trc_data,
  output logic [XLEN-1:0]                  trc_pc,
  output logic [SEQ_W-1:0]                 trc_seq,
  output logic [$clog2(DEPTH):0]           level,
  output logic                             overflow,
  output logic [SEQ_W-1:0]                 drop_count
);
  import trace_pkg::*;

  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [SEQ_W-1:0] drop_count_q, drop_count_d;

  logic             capture, pop, drop;
  logic             fifo_full, fifo_empty;
  trace_entry_t     push_entry, head_entry;

  assign push_entry = '{rd: wb_rd, data: wb_data, pc: wb_pc, seq: seq_q};

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Capture filter, sequence tagging and drop accounting.
  always_comb begin
    seq_d        = seq_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    capture      = wb_we && (wb_rd != '0);
    pop          = !fifo_empty && trc_ready;
    drop         = capture && fifo_full && !pop;
    if (capture) begin
      seq_d = seq_q + SEQ_W'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Payload is forced to zero whenever the FIFO holds nothing.
  assign trc_valid  = !fifo_empty;
  assign trc_rd     = fifo_empty ? '0 : head_entry.rd;
  assign trc_data   = fifo_empty ? '0 : head_entry.data;
  assign trc_pc     = fifo_empty ? '0 : head_entry.pc;
  assign trc_seq    = fifo_empty ? '0 : head_entry.seq;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_commit_trace_buffer;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, wb_we, trc_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc;
  logic        trc_valid, overflow;
  logic [4:0]  trc_rd;
  logic [31:0] trc_data, trc_pc;
  logic [15:0] trc_seq, drop_count;
  logic [3:0]  level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_rd(trc_rd),
    .trc_data(trc_data), .trc_pc(trc_pc), .trc_seq(trc_seq), .level(level),
    .overflow(overflow), .drop_count(drop_count)
  );

  // Reference model: an ordered list of buffered writes plus counters.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic [15:0] seq;
  } ent_t;

  ent_t        m_q[$];
  int unsigned m_seq;
  bit          m_ovf;
  int unsigned m_drops;

  typedef struct {
    bit          r, we, ready;
    logic [4:0]  rd;
    logic [31:0] data, pc;
    bit          ev;
    logic [4:0]  erd;
    logic [31:0] edata, epc;
    logic [15:0] eseq;
    int          elevel;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit we, input logic [4:0] rd,
                            input logic [31:0] data, input logic [31:0] pc, input bit ready);
    bit   did_pop, cap, was_full;
    ent_t e;
    if (r) begin
      m_q.delete();
      m_seq = 0; m_ovf = 0; m_drops = 0;
      return;
    end
    did_pop  = (m_q.size() > 0) && ready;
    cap      = we && (rd != 5'd0);
    was_full = (m_q.size() == DEPTH);
    if (did_pop) void'(m_q.pop_front());
    if (cap) begin
      if (!was_full || did_pop) begin
        e.rd = rd; e.data = data; e.pc = pc; e.seq = 16'(m_seq);
        m_q.push_back(e);
      end else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
      m_seq = (m_seq + 1) % 65536;
    end
  endtask

  // Drive one cycle, advance the model, then sample 1 time unit after the edge.
  task automatic step(input bit r, input bit we, input logic [4:0] rd,
                      input logic [31:0] data, input logic [31:0] pc, input bit ready);
    rst = r; wb_we = we; wb_rd = rd; wb_data = data; wb_pc = pc; trc_ready = ready;
    @(posedge clk);
    model_step(r, we, rd, data, pc, ready);
    #1;
  endtask

  task automatic check_model(input string tag);
    bit v;
    v = (m_q.size() > 0);
    chk({tag, ".valid"}, 64'(trc_valid), 64'(v));
    chk({tag, ".level"}, 64'(level), 64'(m_q.size()));
    chk({tag, ".rd"},    64'(trc_rd),   v ? 64'(m_q[0].rd)   : 64'd0);
    chk({tag, ".data"},  64'(trc_data), v ? 64'(m_q[0].data) : 64'd0);
    chk({tag, ".pc"},    64'(trc_pc),   v ? 64'(m_q[0].pc)   : 64'd0);
    chk({tag, ".seq"},   64'(trc_seq),  v ? 64'(m_q[0].seq)  : 64'd0);
    chk({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
    chk({tag, ".drops"}, 64'(drop_count), 64'(m_drops));
  endtask

  task automatic do_reset();
    step(1, 0, 5'd0, 32'd0, 32'd0, 0);
  endtask

  vec_t vecs[9];

  initial begin
    rst = 1; wb_we = 0; wb_rd = 0; wb_data = 0; wb_pc = 0; trc_ready = 0;

    // {r,we,ready,rd,data,pc, ev,erd,edata,epc,eseq,elevel}
    vecs[0] = '{1,0,0, 5'd0, 32'h0,  32'h0,  0, 5'd0, 32'h0,  32'h0,  16'd0, 0};
    vecs[1] = '{0,1,0, 5'd5, 32'hA,  32'h10, 1, 5'd5, 32'hA,  32'h10, 16'd0, 1};
    vecs[2] = '{0,0,1, 5'd0, 32'h0,  32'h0,  0, 5'd0, 32'h0,  32'h0,  16'd0, 0};
    vecs[3] = '{1,0,0, 5'd0, 32'h0,  32'h0,  0, 5'd0, 32'h0,  32'h0,  16'd0, 0};
    vecs[4] = '{0,1,0, 5'd0, 32'h77, 32'h4,  0, 5'd0, 32'h0,  32'h0,  16'd0, 0};
    vecs[5] = '{0,1,0, 5'd0, 32'h78, 32'h8,  0, 5'd0, 32'h0,  32'h0,  16'd0, 0};
    vecs[6] = '{0,1,0, 5'd0, 32'h79, 32'hC,  0, 5'd0, 32'h0,  32'h0,  16'd0, 0};
    vecs[7] = '{0,1,0, 5'd1, 32'h11, 32'h20, 1, 5'd1, 32'h11, 32'h20, 16'd0, 1};
    vecs[8] = '{0,0,1, 5'd0, 32'h0,  32'h0,  0, 5'd0, 32'h0,  32'h0,  16'd0, 0};

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].r, vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].pc, vecs[i].ready);
      chk($sformatf("vec%0d.valid", i), 64'(trc_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d.rd", i),    64'(trc_rd),    64'(vecs[i].erd));
      chk($sformatf("vec%0d.data", i),  64'(trc_data),  64'(vecs[i].edata));
      chk($sformatf("vec%0d.pc", i),    64'(trc_pc),    64'(vecs[i].epc));
      chk($sformatf("vec%0d.seq", i),   64'(trc_seq),   64'(vecs[i].eseq));
      chk($sformatf("vec%0d.level", i), 64'(level),     64'(vecs[i].elevel));
    end

    // Overflow: ten writes into eight slots, then drain in order.
    do_reset();
    for (int i = 1; i <= 10; i++) step(0, 1, 5'(i), 32'(i * 3), 32'(i * 4), 0);
    chk("ovf.level", 64'(level), 64'd8);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.drops", 64'(drop_count), 64'd2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.seq", i), 64'(trc_seq), 64'(i));
      chk($sformatf("drain%0d.rd", i), 64'(trc_rd), 64'(i + 1));
      step(0, 0, 5'd0, 32'd0, 32'd0, 1);
    end
    chk("drain.valid", 64'(trc_valid), 64'd0);
    check_model("drain");

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 1; i <= 8; i++) step(0, 1, 5'(i), 32'(i), 32'(i), 0);
    step(0, 1, 5'd9, 32'h99, 32'h900, 1);
    chk("fullpp.level", 64'(level), 64'd8);
    chk("fullpp.drops", 64'(drop_count), 64'd0);
    chk("fullpp.ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 5'd0, 32'd0, 32'd0, 1);
    chk("fullpp.tail_rd", 64'(trc_rd), 64'd9);
    chk("fullpp.tail_data", 64'(trc_data), 64'h99);
    chk("fullpp.tail_seq", 64'(trc_seq), 64'd8);
    check_model("fullpp");

    // Streaming with the consumer always ready; pointers wrap several times.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 5'(i % 31 + 1), 32'(i * 7), 32'(i * 4), 1);
      chk($sformatf("stream%0d.seq", i), 64'(trc_seq), 64'(i));
      chk($sformatf("stream%0d.level", i), 64'(level), 64'd1);
    end
    chk("stream.drops", 64'(drop_count), 64'd0);
    check_model("stream");

    // Reset mid-operation with entries buffered and overflow set.
    do_reset();
    for (int i = 1; i <= 10; i++) step(0, 1, 5'(i), 32'(i), 32'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 5'd0, 32'd0, 32'd0, 1);
    chk("midrst.pre_level", 64'(level), 64'd5);
    chk("midrst.pre_ovf", 64'(overflow), 64'd1);
    step(1, 1, 5'd3, 32'h5, 32'h6, 1);
    chk("midrst.valid", 64'(trc_valid), 64'd0);
    chk("midrst.level", 64'(level), 64'd0);
    chk("midrst.ovf", 64'(overflow), 64'd0);
    chk("midrst.drops", 64'(drop_count), 64'd0);
    chk("midrst.payload", {trc_rd, trc_data, trc_seq}, 64'd0);
    step(0, 1, 5'd4, 32'h44, 32'h40, 0);
    chk("midrst.next_seq", 64'(trc_seq), 64'd0);
    chk("midrst.next_rd", 64'(trc_rd), 64'd4);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit          r, we, rdy;
      logic [4:0]  rd;
      r   = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rdy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(r, we, rd, $urandom, $urandom, rdy);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Observation-side counterpart to the CPU stimulus bench: captures every architectural register write retired by the writeback stage of `Pipeline_top` into a small FIFO and hands entries to a consumer (bench checker, debug port) over a valid/ready interface. Sits beside the pipeline, tapping the WB-stage register-file write signals; it never back-pressures the CPU. Writes that cannot be buffered are dropped, counted and flagged, and sequence numbers expose the gaps.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `XLEN`, 32: data and PC width.
- `SEQ_W`, 16: width of sequence and drop counters.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `wb_we`  in  1  WB-stage register write enable (RegWriteW).
- `wb_rd`  in  5  destination register.
- `wb_data`  in  XLEN  value written.
- `wb_pc`  in  XLEN  PC of the retiring instruction.
- `trc_valid`  out  1  head entry available.
- `trc_ready`  in  1  consumer accepts head entry.
- `trc_rd`  out  5  head entry rd.
- `trc_data`  out  XLEN  head entry data.
- `trc_pc`  out  XLEN  head entry PC.
- `trc_seq`  out  SEQ_W  head entry sequence number.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one entry dropped since reset.
- `drop_count`  out  SEQ_W  dropped entries, saturating.

## Operation
- Capture event: `wb_we=1` and `wb_rd!=0`. Writes to x0 are ignored entirely (no push, no sequence increment).
- Each capture event is tagged with the current `seq` value; `seq` then increments by 1, wrapping modulo 2^SEQ_W. `seq` increments on dropped events too, so the consumer sees gaps.
- Pop: `trc_valid && trc_ready` at a rising edge removes the head.
- Push on capture event when not full, or when full and a pop occurs in the same cycle (simultaneous push+pop at full is accepted; level unchanged).
- Full, capture event, no pop: entry discarded; `overflow` set; `drop_count` increments, saturating at 2^SEQ_W−1.
- Empty with simultaneous capture: entry pushed; no pop (trc_valid was 0), so no same-cycle bypass.
- `trc_ready` while `trc_valid=0` has no effect.
- When empty, `trc_rd`, `trc_data`, `trc_pc` and `trc_seq` are driven to 0.
- Pointers wrap modulo DEPTH; `level` ranges 0..DEPTH.

## Timing
- Reset values (after any edge with `rst=1`): `level=0`, `trc_valid=0`, all `trc_*` payloads 0, `seq=0`, `overflow=0`, `drop_count=0`, pointers 0. Storage contents need not be cleared.
- `rst` takes priority over all inputs in the same cycle; reset mid-stream discards all buffered entries, and the first capture after reset is tagged seq 0.
- Capture-to-output latency: 1 cycle. An event sampled at edge N makes `trc_valid=1` with that payload immediately after edge N if the FIFO was empty.
- Outputs (`trc_*`, `level`, `overflow`, `drop_count`) are functions of registered state only. There is no combinational path from `wb_*` or `trc_ready` to any output.
- Throughput: one push and one pop per cycle, sustained.
- Consumer may hold `trc_ready=1` continuously. Payload is stable while `trc_valid=1` and `trc_ready=0`.

## Structure
- Shared package `trace_pkg`: `XLEN`, `REG_ADDR_W=5`, `SEQ_W`, and packed typedef `trace_entry_t` with fields {rd, data, pc, seq}.
- Sub-module `trace_fifo`: generic synchronous first-word-fall-through FIFO parameterised by width and DEPTH, with push/pop/full/empty/level.
- Top level holds the capture filter, sequence counter, drop logic and output zeroing.

## Test plan
- Reset then a single write, `wb_we=1 rd=5 data=0x0000_000A pc=0x0000_0010`, `trc_ready=0` -> next cycle `trc_valid=1 rd=5 data=0xA pc=0x10 seq=0 level=1`. Raise `trc_ready` -> following cycle `trc_valid=0`, payloads 0.
- x0 filter: `wb_we=1 rd=0` for 3 cycles, then rd=1 -> only one entry, with seq=0.
- Overflow: `trc_ready=0`, 10 consecutive writes rd=1..10, DEPTH=8 -> `level=8`, `overflow=1`, `drop_count=2`. Draining yields seq 0..7 in order, rd 1..8.
- Full with simultaneous push+pop: fill to 8, then one cycle with capture event and `trc_ready=1` -> `level` stays 8, `drop_count` unchanged, last entry present at tail.
- Streaming: writes every cycle with `trc_ready=1` for 40 cycles -> `level` never exceeds 1, seq 0..39 contiguous, no drops. Pointer wrap is exercised.
- Reset mid-operation: 5 entries buffered with `overflow=1`, assert `rst` one cycle -> all outputs at reset values. The next capture is tagged seq 0.
